// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - 640x480 raster counters, registered colour/sync output stage and frame tick.
module vga_scan_engine #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int H_TOTAL   = 800,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int V_TOTAL   = 525
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic [7:0] color_in,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       frame_tick,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n
);

   localparam logic [9:0] H_VIS_C   = 10'(H_VISIBLE);
   localparam logic [9:0] H_SS_C    = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] H_SE_C    = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_VIS_C   = 10'(V_VISIBLE);
   localparam logic [9:0] V_SS_C    = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] V_SE_C    = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);

   logic [9:0] h_count_q, h_count_d;
   logic [9:0] v_count_q, v_count_d;
   logic       frame_tick_q, frame_tick_d;
   logic [7:0] vga_r_q, vga_r_d;
   logic [7:0] vga_g_q, vga_g_d;
   logic [7:0] vga_b_q, vga_b_d;
   logic       vga_hs_q, vga_hs_d;
   logic       vga_vs_q, vga_vs_d;
   logic       vga_blank_n_q, vga_blank_n_d;
   logic       video_on_s;
   logic [2:0] r_s, g_s;
   logic [1:0] b_s;

   assign video_on_s = (h_count_q < H_VIS_C) && (v_count_q < V_VIS_C);
   assign r_s = color_in[7:5];
   assign g_s = color_in[4:2];
   assign b_s = color_in[1:0];

   always_comb begin
      h_count_d = h_count_q + 10'd1;
      v_count_d = v_count_q;
      if (h_count_q == H_LAST_C) begin
         h_count_d = '0;
         v_count_d = (v_count_q == V_LAST_C) ? '0 : v_count_q + 10'd1;
      end
   end

   // Stage 1: everything below describes the pixel currently on the counters.
   always_comb begin
      vga_hs_d      = !((h_count_q >= H_SS_C) && (h_count_q < H_SE_C));
      vga_vs_d      = !((v_count_q >= V_SS_C) && (v_count_q < V_SE_C));
      vga_blank_n_d = video_on_s;
      frame_tick_d  = (h_count_q == '0) && (v_count_q == V_VIS_C);
      vga_r_d       = '0;
      vga_g_d       = '0;
      vga_b_d       = '0;
      if (video_on_s) begin
         vga_r_d = {r_s, r_s, r_s[2:1]};
         vga_g_d = {g_s, g_s, g_s[2:1]};
         vga_b_d = {b_s, b_s, b_s, b_s};
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         h_count_q     <= '0;
         v_count_q     <= '0;
         frame_tick_q  <= 1'b0;
         vga_r_q       <= '0;
         vga_g_q       <= '0;
         vga_b_q       <= '0;
         vga_hs_q      <= 1'b1;
         vga_vs_q      <= 1'b1;
         vga_blank_n_q <= 1'b0;
      end else begin
         h_count_q     <= h_count_d;
         v_count_q     <= v_count_d;
         frame_tick_q  <= frame_tick_d;
         vga_r_q       <= vga_r_d;
         vga_g_q       <= vga_g_d;
         vga_b_q       <= vga_b_d;
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
         vga_blank_n_q <= vga_blank_n_d;
      end
   end

   assign pixel_x     = h_count_q;
   assign pixel_y     = v_count_q;
   assign video_on    = video_on_s;
   assign frame_tick  = frame_tick_q;
   assign vga_r       = vga_r_q;
   assign vga_g       = vga_g_q;
   assign vga_b       = vga_b_q;
   assign vga_hs      = vga_hs_q;
   assign vga_vs      = vga_vs_q;
   assign vga_blank_n = vga_blank_n_q;
   assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb/tb_vga_scan_engine.sv - randomized colour stimulus against a cycle-count raster model, reduced timing.
module tb_vga_scan_engine;

   localparam int HV = 16, HF = 4, HS = 6, HB = 6, HT = 32;
   localparam int VV = 12, VF = 2, VS = 2, VB = 4, VT = 20;
   localparam int FRAME = HT * VT;

   logic       clk_pixel = 1'b0;
   logic       reset;
   logic [7:0] color_in;
   logic [9:0] pixel_x, pixel_y;
   logic       video_on, frame_tick;
   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;

   vga_scan_engine #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .color_in(color_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .frame_tick(frame_tick), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n)
   );

   always #20 clk_pixel = ~clk_pixel;

   int tests = 0, fails = 0;
   int t;                        // cycles since the counters last restarted
   logic [7:0] prev_col;
   bit tally_en = 0;
   int hs_low = 0, vs_low = 0, blank_hi = 0;
   int tick_t[$];
   bit seen_tick;
   int seen_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   function automatic logic [7:0] exp3(input int v);
      return 8'(36 * v + v / 2);
   endfunction

   task automatic cycle(input logic [7:0] col, input logic rst);
      int x, y, px, py;
      bit von, pvon;
      logic [7:0] er, eg, eb;
      logic ehs, evs, etick;
      color_in = col;
      reset    = rst;
      @(negedge clk_pixel);
      x = t % HT;
      y = (t / HT) % VT;
      von = (x < HV) && (y < VV);
      check("pixel_x", pixel_x, x);
      check("pixel_y", pixel_y, y);
      check("video_on", video_on, von);
      check("sync_n", vga_sync_n, 0);
      if (t == 0) begin
         {er, eg, eb} = '0;
         ehs = 1; evs = 1; pvon = 0; etick = 0;
      end else begin
         px = (t - 1) % HT;
         py = ((t - 1) / HT) % VT;
         pvon = (px < HV) && (py < VV);
         er = pvon ? exp3(int'(prev_col[7:5])) : 8'd0;
         eg = pvon ? exp3(int'(prev_col[4:2])) : 8'd0;
         eb = pvon ? 8'(85 * int'(prev_col[1:0])) : 8'd0;
         ehs = !(px >= HV + HF && px < HV + HF + HS);
         evs = !(py >= VV + VF && py < VV + VF + VS);
         etick = ((t - 1) % FRAME) == VV * HT;
      end
      check("vga_r", vga_r, er);
      check("vga_g", vga_g, eg);
      check("vga_b", vga_b, eb);
      check("vga_hs", vga_hs, ehs);
      check("vga_vs", vga_vs, evs);
      check("blank_n", vga_blank_n, pvon);
      check("frame_tick", frame_tick, etick);
      seen_tick = frame_tick;
      seen_t = t;
      if (tally_en && t >= 1 && t <= 2 * FRAME) begin
         hs_low   += (vga_hs == 1'b0);
         vs_low   += (vga_vs == 1'b0);
         blank_hi += (vga_blank_n == 1'b1);
         if (frame_tick) tick_t.push_back(t);
      end
      prev_col = col;
      @(posedge clk_pixel);
      #1;
      if (rst) t = 0; else t++;
   endtask

   initial begin
      #(40 * 100000);
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_tick;
      int guard;
      reset = 1'b1;
      color_in = 8'h00;
      prev_col = 8'h00;
      repeat (3) @(posedge clk_pixel);
      #1;
      t = 0;
      tally_en = 1;
      for (int i = 0; i <= 2 * FRAME; i++) begin
         if (i == 10 * HT + 10) begin
            cycle(8'b111_000_00, 0);
            check("dir_r_ff", vga_r, 8'hFF);
            check("dir_g_00", vga_g, 8'h00);
            check("dir_b_00", vga_b, 8'h00);
         end else if (i == 10 * HT + 11) begin
            cycle(8'b010_101_10, 0);
            check("dir_r_49", vga_r, 8'h49);
            check("dir_g_b6", vga_g, 8'hB6);
            check("dir_b_aa", vga_b, 8'hAA);
         end else if (i == 5 * HT + 20 || i == 14 * HT + 5) begin
            cycle(8'hFF, 0);
            check("blank_rgb", {vga_r, vga_g, vga_b}, 24'h0);
            check("blank_bn", vga_blank_n, 0);
         end else begin
            cycle(8'($urandom), 0);
         end
      end
      tally_en = 0;
      check("hs_low_total", hs_low, 2 * VT * HS);
      check("vs_low_total", vs_low, 2 * VS * HT);
      check("blank_hi_total", blank_hi, 2 * HV * VV);
      check("tick_count", tick_t.size(), 2);
      if (tick_t.size() == 2) begin
         check("tick_first", tick_t[0], VV * HT + 1);
         check("tick_period", tick_t[1] - tick_t[0], FRAME);
      end

      guard = 0;
      while (!(t % HT == 7 && (t / HT) % VT == 5) && guard < 2 * FRAME) begin
         cycle(8'($urandom), 0);
         guard++;
      end
      check("reach_mid", guard < 2 * FRAME, 1);
      cycle(8'($urandom), 1);
      cycle(8'($urandom), 1);
      first_tick = -1;
      for (int i = 0; i < VV * HT + 8; i++) begin
         cycle(8'($urandom), 0);
         if (seen_tick && first_tick < 0) first_tick = seen_t;
      end
      check("tick_after_reset", first_tick, VV * HT + 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
